// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store memory controller:
// funct3 codes, response causes, FSM states and store-lane helpers.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_MISALIGN = 2'd1,
        CAUSE_TIMEOUT  = 2'd2,
        CAUSE_ILLEGAL  = 2'd3
    } cause_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    function automatic logic [3:0] store_strb(
        input logic [2:0] f3,
        input logic [1:0] lo
    );
        case (f3[1:0])
            2'b00:   return 4'b0001 << lo;
            2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(
        input logic [2:0]  f3,
        input logic [31:0] wdata
    );
        case (f3[1:0])
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Core-side request/response bundle and word-aligned memory bus
// between the execute stage, the controller and data memory.
interface lsu_core_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [1:0]  resp_cause;

    modport master (
        output req_valid, req_we, req_func3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, resp_cause
    );
    modport slave (
        input  req_valid, req_we, req_func3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, resp_cause
    );
endinterface

interface lsu_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ack, mem_rdata
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/load_lane_extend.sv
// Selects the addressed byte/half of a loaded word and
// sign- or zero-extends it according to the load funct3.
module load_lane_extend
    import lsu_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_func3,
    input  logic [31:0] i_word,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
        w_half = i_word[{i_addr_lo[1], 4'b0000} +: 16];
        case (i_func3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_data = {24'h0, w_byte};
            F3_LHU:  o_data = {16'h0, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer: validates a request, runs one req/ack memory
// transaction with a timeout, and returns a single response pulse.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic        clk,
    input logic        rst_n,
    lsu_core_if.slave  core,
    lsu_mem_if.master  mem
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_e      r_state;
    logic        r_ready;
    logic        r_we;
    logic [2:0]  r_func3;
    logic [1:0]  r_addr_lo;
    logic [CW-1:0] r_cnt;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_wstrb;
    logic [31:0] r_mem_wdata;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;
    cause_e      r_resp_cause;

    logic        w_legal;
    logic        w_misalign;
    logic        w_timeout;
    logic [31:0] w_ld_data;

    always_comb begin
        if (core.req_we)
            w_legal = core.req_func3 inside {F3_SB, F3_SH, F3_SW};
        else
            w_legal = core.req_func3 inside {F3_LB, F3_LH, F3_LW,
                                             F3_LBU, F3_LHU};
        w_misalign = (core.req_func3[1:0] == 2'b01 && core.req_addr[0]) ||
                     (core.req_func3[1:0] == 2'b10 &&
                      core.req_addr[1:0] != 2'b00);
        w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);
    end

    load_lane_extend u_ext (
        .i_addr_lo (r_addr_lo),
        .i_func3   (r_func3),
        .i_word    (mem.mem_rdata),
        .o_data    (w_ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_ready      <= 1'b1;
            r_we         <= 1'b0;
            r_func3      <= '0;
            r_addr_lo    <= '0;
            r_cnt        <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wstrb  <= '0;
            r_mem_wdata  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_resp_cause <= CAUSE_NONE;
        end else begin
            // Response fields live for exactly one cycle.
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_resp_cause <= CAUSE_NONE;
            unique case (r_state)
                S_IDLE: begin
                    if (core.req_valid) begin
                        r_ready   <= 1'b0;
                        r_we      <= core.req_we;
                        r_func3   <= core.req_func3;
                        r_addr_lo <= core.req_addr[1:0];
                        r_cnt     <= '0;
                        if (!w_legal || w_misalign) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_cause <= !w_legal ? CAUSE_ILLEGAL
                                                     : CAUSE_MISALIGN;
                        end else begin
                            r_state     <= S_ACCESS;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= core.req_we;
                            r_mem_addr  <= {core.req_addr[31:2], 2'b00};
                            r_mem_wstrb <= core.req_we ?
                                store_strb(core.req_func3,
                                           core.req_addr[1:0]) : 4'b0000;
                            r_mem_wdata <= core.req_we ?
                                store_lanes(core.req_func3,
                                            core.req_wdata) : 32'h0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (mem.mem_ack || w_timeout) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_mem_req    <= 1'b0;
                        r_mem_we     <= 1'b0;
                        r_mem_addr   <= '0;
                        r_mem_wstrb  <= '0;
                        r_mem_wdata  <= '0;
                        // Ack wins over a coincident timeout.
                        if (mem.mem_ack) begin
                            r_resp_rdata <= r_we ? 32'h0 : w_ld_data;
                        end else begin
                            r_resp_err   <= 1'b1;
                            r_resp_cause <= CAUSE_TIMEOUT;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign core.req_ready  = r_ready;
    assign core.resp_valid = r_resp_valid;
    assign core.resp_rdata = r_resp_rdata;
    assign core.resp_err   = r_resp_err;
    assign core.resp_cause = r_resp_cause;
    assign mem.mem_req     = r_mem_req;
    assign mem.mem_we      = r_mem_we;
    assign mem.mem_addr    = r_mem_addr;
    assign mem.mem_wstrb   = r_mem_wstrb;
    assign mem.mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: default-timeout instance for the
// datapath cases and a 4-cycle-timeout instance for timeout cases.
module tb_lsu_mem_ctrl;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    lsu_core_if core_a ();
    lsu_mem_if  mem_a ();
    lsu_core_if core_b ();
    lsu_mem_if  mem_b ();

    lsu_mem_ctrl u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .core  (core_a.slave),
        .mem   (mem_a.master)
    );

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(4)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .core  (core_b.slave),
        .mem   (mem_b.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_a(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        core_a.req_valid = 1'b1;
        core_a.req_we    = we;
        core_a.req_func3 = f3;
        core_a.req_addr  = addr;
        core_a.req_wdata = wd;
        tick();
        core_a.req_valid = 1'b0;
    endtask

    task automatic issue_b(input logic [2:0] f3, input logic [31:0] addr);
        @(negedge clk);
        core_b.req_valid = 1'b1;
        core_b.req_we    = 1'b0;
        core_b.req_func3 = f3;
        core_b.req_addr  = addr;
        core_b.req_wdata = 32'h0;
        tick();
        core_b.req_valid = 1'b0;
    endtask

    int reqcnt;
    int respcnt;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        core_a.req_valid = 1'b0;
        core_a.req_we    = 1'b0;
        core_a.req_func3 = 3'b0;
        core_a.req_addr  = 32'h0;
        core_a.req_wdata = 32'h0;
        core_b.req_valid = 1'b0;
        core_b.req_we    = 1'b0;
        core_b.req_func3 = 3'b0;
        core_b.req_addr  = 32'h0;
        core_b.req_wdata = 32'h0;
        mem_a.mem_ack    = 1'b0;
        mem_a.mem_rdata  = 32'h0;
        mem_b.mem_ack    = 1'b0;
        mem_b.mem_rdata  = 32'h0;
        repeat (2) tick();

        chk("rst_ready", 32'(core_a.req_ready), 32'd1);
        chk("rst_memreq", 32'(mem_a.mem_req), 32'd0);
        chk("rst_respv", 32'(core_a.resp_valid), 32'd0);
        chk("rst_rdata", core_a.resp_rdata, 32'h0);
        chk("rst_wstrb", 32'(mem_a.mem_wstrb), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // LB 0x103, zero-wait ack
        issue_a(1'b0, 3'b000, 32'h0000_0103, 32'h0);
        chk("lb_memreq", 32'(mem_a.mem_req), 32'd1);
        chk("lb_addr", mem_a.mem_addr, 32'h0000_0100);
        chk("lb_wstrb", 32'(mem_a.mem_wstrb), 32'h0);
        chk("lb_busy", 32'(core_a.req_ready), 32'd0);
        chk("lb_noresp", 32'(core_a.resp_valid), 32'd0);
        mem_a.mem_ack   = 1'b1;
        mem_a.mem_rdata = 32'h80FF_1234;
        tick();
        mem_a.mem_ack = 1'b0;
        chk("lb_respv", 32'(core_a.resp_valid), 32'd1);
        chk("lb_rdata", core_a.resp_rdata, 32'hFFFF_FF80);
        chk("lb_err", 32'(core_a.resp_err), 32'd0);
        chk("lb_memreq_drop", 32'(mem_a.mem_req), 32'd0);
        tick();
        chk("lb_pulse", 32'(core_a.resp_valid), 32'd0);
        chk("lb_rdata_clr", core_a.resp_rdata, 32'h0);
        chk("lb_ready", 32'(core_a.req_ready), 32'd1);

        // LHU 0x102, ack after 5 wait cycles
        issue_a(1'b0, 3'b101, 32'h0000_0102, 32'h0);
        reqcnt = mem_a.mem_req ? 1 : 0;
        repeat (5) begin
            tick();
            reqcnt += mem_a.mem_req ? 1 : 0;
        end
        chk("lhu_reqcnt", 32'(reqcnt), 32'd6);
        chk("lhu_addr_stable", mem_a.mem_addr, 32'h0000_0100);
        chk("lhu_noresp", 32'(core_a.resp_valid), 32'd0);
        mem_a.mem_ack   = 1'b1;
        mem_a.mem_rdata = 32'h8001_0000;
        tick();
        mem_a.mem_ack = 1'b0;
        chk("lhu_respv", 32'(core_a.resp_valid), 32'd1);
        chk("lhu_rdata", core_a.resp_rdata, 32'h0000_8001);
        chk("lhu_err", 32'(core_a.resp_err), 32'd0);
        tick();

        // LH 0x100, sign-extend the low half
        issue_a(1'b0, 3'b001, 32'h0000_0100, 32'h0);
        mem_a.mem_ack   = 1'b1;
        mem_a.mem_rdata = 32'h1234_F00D;
        tick();
        mem_a.mem_ack = 1'b0;
        chk("lh_rdata", core_a.resp_rdata, 32'hFFFF_F00D);
        tick();

        // SB 0x201
        issue_a(1'b1, 3'b000, 32'h0000_0201, 32'h0000_00AB);
        chk("sb_we", 32'(mem_a.mem_we), 32'd1);
        chk("sb_wstrb", 32'(mem_a.mem_wstrb), 32'h2);
        chk("sb_wdata", mem_a.mem_wdata, 32'hABAB_ABAB);
        chk("sb_addr", mem_a.mem_addr, 32'h0000_0200);
        mem_a.mem_ack   = 1'b1;
        mem_a.mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_a.mem_ack = 1'b0;
        chk("sb_respv", 32'(core_a.resp_valid), 32'd1);
        chk("sb_rdata", core_a.resp_rdata, 32'h0);
        chk("sb_err", 32'(core_a.resp_err), 32'd0);
        tick();

        // SH 0x206
        issue_a(1'b1, 3'b001, 32'h0000_0206, 32'h1234_5678);
        chk("sh_wstrb", 32'(mem_a.mem_wstrb), 32'hC);
        chk("sh_wdata", mem_a.mem_wdata, 32'h5678_5678);
        mem_a.mem_ack = 1'b1;
        tick();
        mem_a.mem_ack = 1'b0;
        tick();

        // LW misaligned: no memory access, response next cycle
        issue_a(1'b0, 3'b010, 32'h0000_0102, 32'h0);
        chk("lwmis_memreq", 32'(mem_a.mem_req), 32'd0);
        chk("lwmis_respv", 32'(core_a.resp_valid), 32'd1);
        chk("lwmis_err", 32'(core_a.resp_err), 32'd1);
        chk("lwmis_cause", 32'(core_a.resp_cause), 32'd1);
        tick();
        chk("lwmis_pulse", 32'(core_a.resp_valid), 32'd0);
        chk("lwmis_ready", 32'(core_a.req_ready), 32'd1);

        // Store funct3 100 is illegal
        issue_a(1'b1, 3'b100, 32'h0000_0100, 32'h0);
        chk("st100_err", 32'(core_a.resp_err), 32'd1);
        chk("st100_cause", 32'(core_a.resp_cause), 32'd3);
        chk("st100_memreq", 32'(mem_a.mem_req), 32'd0);
        tick();

        // Illegal funct3 beats misalignment
        issue_a(1'b1, 3'b101, 32'h0000_0101, 32'h0);
        chk("prio_cause", 32'(core_a.resp_cause), 32'd3);
        tick();

        // Timeout instance: 4 ACCESS cycles without ack
        issue_b(3'b010, 32'h0000_0300);
        repeat (3) tick();
        chk("to_req4", 32'(mem_b.mem_req), 32'd1);
        chk("to_noresp4", 32'(core_b.resp_valid), 32'd0);
        tick();
        chk("to_respv", 32'(core_b.resp_valid), 32'd1);
        chk("to_err", 32'(core_b.resp_err), 32'd1);
        chk("to_cause", 32'(core_b.resp_cause), 32'd2);
        chk("to_memreq", 32'(mem_b.mem_req), 32'd0);
        mem_b.mem_ack   = 1'b1;
        mem_b.mem_rdata = 32'hCAFE_F00D;
        tick();
        chk("late_ack_respv", 32'(core_b.resp_valid), 32'd0);
        chk("late_ack_ready", 32'(core_b.req_ready), 32'd1);
        tick();
        mem_b.mem_ack = 1'b0;
        chk("late_ack_idle", 32'(core_b.resp_valid), 32'd0);

        // Ack on the 4th ACCESS cycle beats the timeout
        issue_b(3'b010, 32'h0000_0300);
        repeat (3) tick();
        mem_b.mem_ack   = 1'b1;
        mem_b.mem_rdata = 32'h1122_3344;
        tick();
        mem_b.mem_ack = 1'b0;
        chk("ack4_respv", 32'(core_b.resp_valid), 32'd1);
        chk("ack4_err", 32'(core_b.resp_err), 32'd0);
        chk("ack4_cause", 32'(core_b.resp_cause), 32'd0);
        chk("ack4_rdata", core_b.resp_rdata, 32'h1122_3344);
        tick();

        // Asynchronous reset during ACCESS
        issue_a(1'b0, 3'b010, 32'h0000_0400, 32'h0);
        chk("rst_pre_req", 32'(mem_a.mem_req), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_memreq", 32'(mem_a.mem_req), 32'd0);
        chk("arst_ready", 32'(core_a.req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        respcnt = 0;
        repeat (4) begin
            tick();
            respcnt += core_a.resp_valid ? 1 : 0;
        end
        chk("arst_noresp", 32'(respcnt), 32'd0);

        // Stray ack while idle
        @(negedge clk);
        mem_a.mem_ack   = 1'b1;
        mem_a.mem_rdata = 32'h5555_AAAA;
        tick();
        tick();
        chk("stray_memreq", 32'(mem_a.mem_req), 32'd0);
        chk("stray_respv", 32'(core_a.resp_valid), 32'd0);
        chk("stray_ready", 32'(core_a.req_ready), 32'd1);
        mem_a.mem_ack = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
